// File: rtl/tdm_pkg.sv
// Shared types and helpers for the TDM frame multiplexer.
// Carries the FSM state encoding, the default parallel frame width and a
// constant-foldable clog2 used to size select and counter fields.
package tdm_pkg;

  localparam int TDM_FRAME_W = 32'sd256;

  typedef enum logic [1:0] {
    PASS = 2'd0,
    PEND = 2'd1,
    MUTE = 2'd2
  } tdm_mux_state_t;

  // Number of bits needed to encode values 0 .. value-1.
  function automatic int clog2(input int value);
    int res;
    int rem;
    res = 32'sd0;
    rem = value - 32'sd1;
    while (rem > 32'sd0) begin
      res = res + 32'sd1;
      rem = rem >>> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/tdm_frame_mux_if.sv
// Frame-mux bus: source select, per-source frame strobes/data and the
// forwarded frame plus status. The slave modport is the mux itself; the
// master modport is whatever feeds it and observes the result.
interface tdm_frame_mux_if
  import tdm_pkg::*;
#(
  parameter int NUM_SRC = 2,
  parameter int DATA_W  = TDM_FRAME_W,
  parameter int SEL_W   = clog2(NUM_SRC)
);

  logic [SEL_W-1:0]          sel;
  logic [NUM_SRC-1:0]        srcValid;
  logic [NUM_SRC*DATA_W-1:0] srcData;
  logic                      tdmPdataValidX;
  logic [DATA_W-1:0]         tdmPdataX;
  logic [SEL_W-1:0]          activeSel;
  logic                      switchBusy;
  logic                      los;

  modport master (
    output sel, srcValid, srcData,
    input  tdmPdataValidX, tdmPdataX, activeSel, switchBusy, los
  );

  modport slave (
    input  sel, srcValid, srcData,
    output tdmPdataValidX, tdmPdataX, activeSel, switchBusy, los
  );

endinterface

// File: rtl/tdm_los_wdog.sv
// Loss-of-signal watchdog for the active frame source.
// Counts clock cycles since the last kick, saturating at LOS_CYCLES; the
// registered los flag is high while the count sits at the limit. A kick or
// clear restarts the count and drops the flag. Only built with
// TDM_MUX_LOS_EN.
module tdm_los_wdog
  import tdm_pkg::*;
#(
  parameter int LOS_CYCLES = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic kick,
  input  logic clear,
  output logic los
);

  localparam int                CNT_W   = clog2(LOS_CYCLES + 32'sd1);
  localparam logic [CNT_W-1:0]  LIMIT_C = CNT_W'(LOS_CYCLES);
  localparam logic [CNT_W-1:0]  ONE_C   = CNT_W'(1);

  logic [CNT_W-1:0] cnt_r;
  logic             los_r;

  // Silence counter with saturation; flag registered alongside the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
      los_r <= 1'b0;
    end else if (kick || clear) begin
      cnt_r <= '0;
      los_r <= 1'b0;
    end else if (cnt_r != LIMIT_C) begin
      cnt_r <= cnt_r + ONE_C;
      los_r <= ((cnt_r + ONE_C) == LIMIT_C);
    end else begin
      cnt_r <= cnt_r;
      los_r <= 1'b1;
    end
  end

  assign los = los_r;

endmodule

// File: rtl/tdm_frame_mux.sv
// N-way frame-aligned selector for parallel TDM frames.
// A source switch is armed by sel and completes only on a frame strobe from
// the new source, so frames are never torn; the old source keeps streaming
// untouched until then. The first MUTE_FRAMES frames after completion are
// forwarded as zero data to avoid audible pops.
// Optional feature: define TDM_MUX_LOS_EN to build the loss-of-signal
// watchdog (tdm_los_wdog); without it los is tied low.
module tdm_frame_mux
  import tdm_pkg::*;
#(
  parameter int NUM_SRC     = 2,
  parameter int DATA_W      = TDM_FRAME_W,
  parameter int MUTE_FRAMES = 4,
  parameter int RESET_SEL   = 0,
  parameter int LOS_CYCLES  = 4096
) (
  input  logic         clk,
  input  logic         rst,
  tdm_frame_mux_if.slave bus
);

  localparam int SEL_W  = clog2(NUM_SRC);
  localparam int MUTE_W = (clog2(MUTE_FRAMES + 32'sd1) < 32'sd1) ? 32'sd1
                                                                : clog2(MUTE_FRAMES + 32'sd1);

  localparam logic [SEL_W-1:0]  RESET_SEL_C   = SEL_W'(RESET_SEL);
  localparam logic [SEL_W:0]    NUM_SRC_C     = (SEL_W + 1)'(NUM_SRC);
  localparam logic [MUTE_W-1:0] MUTE_RELOAD_C = (MUTE_FRAMES > 32'sd0) ? MUTE_W'(MUTE_FRAMES - 32'sd1)
                                                                      : '0;
  localparam logic [MUTE_W-1:0] MUTE_ONE_C    = MUTE_W'(1);

  // Reject parameter sets the datapath cannot represent.
  if ((NUM_SRC < 32'sd2) || (RESET_SEL < 32'sd0) || (RESET_SEL >= NUM_SRC) ||
      (MUTE_FRAMES < 32'sd0) || (LOS_CYCLES < 32'sd1)) begin : g_bad_cfg
    $error("tdm_frame_mux: illegal parameter set");
  end

  tdm_mux_state_t    state_r;
  logic [SEL_W-1:0]  active_sel_r;
  logic [SEL_W-1:0]  target_r;
  logic [MUTE_W-1:0] mute_cnt_r;
  logic              valid_r;
  logic [DATA_W-1:0] data_r;
  logic              busy_r;

  logic [DATA_W-1:0] src_frame_s [NUM_SRC];
  logic              sel_ok_s;
  logic              sel_new_s;
  logic              act_valid_s;
  logic              tgt_valid_s;
  logic [DATA_W-1:0] act_frame_s;
  logic [DATA_W-1:0] tgt_frame_s;
  logic              request_s;
  logic              cancel_s;
  logic              complete_s;

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_split
    assign src_frame_s[gi] = bus.srcData[gi*DATA_W +: DATA_W];
  end

  // Classify this cycle's sel request and pick out active/target frames.
  // A sel change outranks a target strobe in the same cycle.
  always_comb begin
    sel_ok_s    = ({1'b0, bus.sel} < NUM_SRC_C);
    sel_new_s   = sel_ok_s && (bus.sel != active_sel_r);
    act_valid_s = bus.srcValid[active_sel_r];
    tgt_valid_s = bus.srcValid[target_r];
    act_frame_s = src_frame_s[active_sel_r];
    tgt_frame_s = src_frame_s[target_r];
    request_s   = 1'b0;
    cancel_s    = 1'b0;
    complete_s  = 1'b0;
    case (state_r)
      PASS: request_s = sel_new_s;
      PEND: begin
        if (sel_new_s && (bus.sel != target_r)) begin
          request_s = 1'b1;
        end else if (sel_ok_s && (bus.sel == active_sel_r)) begin
          cancel_s = 1'b1;
        end else begin
          complete_s = tgt_valid_s;
        end
      end
      MUTE:    request_s = sel_new_s;
      default: request_s = 1'b0;
    endcase
  end

  // Switch FSM with registered frame output and busy flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= PASS;
      active_sel_r <= RESET_SEL_C;
      target_r     <= RESET_SEL_C;
      mute_cnt_r   <= '0;
      valid_r      <= 1'b0;
      data_r       <= '0;
      busy_r       <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      case (state_r)
        PASS: begin
          if (act_valid_s) begin
            valid_r <= 1'b1;
            data_r  <= act_frame_s;
          end
          if (request_s) begin
            target_r <= bus.sel;
            state_r  <= PEND;
            busy_r   <= 1'b1;
          end
        end
        PEND: begin
          if (complete_s) begin
            // Only the new source's frame goes out on the completing cycle.
            active_sel_r <= target_r;
            valid_r      <= 1'b1;
            if (MUTE_FRAMES == 32'sd0) begin
              data_r  <= tgt_frame_s;
              state_r <= PASS;
              busy_r  <= 1'b0;
            end else begin
              data_r     <= '0;
              mute_cnt_r <= MUTE_RELOAD_C;
              if (MUTE_RELOAD_C == '0) begin
                state_r <= PASS;
                busy_r  <= 1'b0;
              end else begin
                state_r <= MUTE;
                busy_r  <= 1'b1;
              end
            end
          end else begin
            if (act_valid_s) begin
              valid_r <= 1'b1;
              data_r  <= act_frame_s;
            end
            if (request_s) begin
              target_r <= bus.sel;
            end
            if (cancel_s) begin
              state_r <= PASS;
              busy_r  <= 1'b0;
            end
          end
        end
        MUTE: begin
          if (request_s) begin
            // Abandon the current mute window; the next switch mutes anew.
            target_r   <= bus.sel;
            state_r    <= PEND;
            mute_cnt_r <= '0;
            busy_r     <= 1'b1;
            if (act_valid_s) begin
              valid_r <= 1'b1;
              data_r  <= act_frame_s;
            end
          end else if (act_valid_s) begin
            valid_r <= 1'b1;
            data_r  <= '0;
            if (mute_cnt_r <= MUTE_ONE_C) begin
              mute_cnt_r <= '0;
              state_r    <= PASS;
              busy_r     <= 1'b0;
            end else begin
              mute_cnt_r <= mute_cnt_r - MUTE_ONE_C;
            end
          end else begin
            mute_cnt_r <= mute_cnt_r;
          end
        end
        default: begin
          state_r    <= PASS;
          mute_cnt_r <= '0;
          busy_r     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.tdmPdataValidX = valid_r;
  assign bus.tdmPdataX      = data_r;
  assign bus.activeSel      = active_sel_r;
  assign bus.switchBusy     = busy_r;

`ifdef TDM_MUX_LOS_EN
  logic los_s;

  tdm_los_wdog #(
    .LOS_CYCLES (LOS_CYCLES)
  ) u_los_wdog (
    .clk   (clk),
    .rst   (rst),
    .kick  (act_valid_s),
    .clear (complete_s),
    .los   (los_s)
  );

  assign bus.los = los_s;
`else
  assign bus.los = 1'b0;
`endif

endmodule
